// File: rtl/vreg_ramp_ctrl.sv
// Manual voltage-regulator ramp sequencer: steps an 8-bit DAC code up/down on Vup/Vdn edges,
// with per-step spacing, limit clamping, low-VDD standby and constant-driver bypass.
module vreg_ramp_ctrl #(
    parameter logic [7:0] V_INIT = 8'd128,
    parameter logic [7:0] V_MIN  = 8'd64,
    parameter logic [7:0] V_MAX  = 8'd200,
    parameter logic [7:0] V_STBY = 8'd32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Pwr_mode,
    input  logic       Vup,
    input  logic       Vdn,
    input  logic       v_source_select,
    input  logic [4:0] count,
    input  logic [7:0] rampTime,
    output logic [7:0] v_level,
    output logic       step_up,
    output logic       step_dn,
    output logic       busy,
    output logic       done,
    output logic       sat,
    output logic       cmd_err
);

    typedef enum logic [1:0] {S_IDLE, S_RAMP, S_DONE, S_STBY} state_t;

    state_t     state_q;
    logic       vup_q, vdn_q, dir_q;
    logic [4:0] steps_left_q;
    logic [7:0] period_q, timer_q, v_level_q;
    logic       step_up_q, step_dn_q, busy_q, done_q, sat_q, cmd_err_q;

    logic       up_rise, dn_rise;
    logic [7:0] period_in;
    logic       step_is_up, clamp_d;
    logic [7:0] v_step_d;

    assign up_rise   = Vup & ~vup_q;
    assign dn_rise   = Vdn & ~vdn_q;
    assign period_in = (rampTime == 8'd0) ? 8'd1 : rampTime;

    // Direction of a step taken this cycle: latched in RAMP, freshly decoded on acceptance.
    assign step_is_up = (state_q == S_RAMP) ? dir_q : up_rise;
    assign clamp_d    = step_is_up ? (v_level_q >= V_MAX) : (v_level_q <= V_MIN);
    assign v_step_d   = step_is_up ? (v_level_q + 8'd1) : (v_level_q - 8'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            vup_q        <= 1'b0;
            vdn_q        <= 1'b0;
            dir_q        <= 1'b0;
            steps_left_q <= 5'd0;
            period_q     <= 8'd0;
            timer_q      <= 8'd0;
            v_level_q    <= V_INIT;
            step_up_q    <= 1'b0;
            step_dn_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sat_q        <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            vup_q     <= Vup;
            vdn_q     <= Vdn;
            step_up_q <= 1'b0;
            step_dn_q <= 1'b0;
            done_q    <= 1'b0;
            cmd_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (!Pwr_mode) begin
                        state_q   <= S_STBY;
                        v_level_q <= V_STBY;
                    end else if (!v_source_select) begin
                        state_q <= S_IDLE;
                    end else if (up_rise && dn_rise) begin
                        cmd_err_q <= 1'b1;
                    end else if (up_rise || dn_rise) begin
                        dir_q    <= up_rise;
                        period_q <= period_in;
                        sat_q    <= 1'b0;
                        if (count == 5'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RAMP;
                            busy_q  <= 1'b1;
                            // A one-clock period puts the first step on the accepting edge.
                            if (period_in == 8'd1) begin
                                steps_left_q <= count - 5'd1;
                                timer_q      <= period_in;
                                if (clamp_d) begin
                                    sat_q <= 1'b1;
                                end else begin
                                    v_level_q <= v_step_d;
                                    step_up_q <= step_is_up;
                                    step_dn_q <= ~step_is_up;
                                end
                            end else begin
                                steps_left_q <= count;
                                timer_q      <= period_in - 8'd1;
                            end
                        end
                    end
                end
                S_RAMP: begin
                    if (!Pwr_mode) begin
                        state_q   <= S_STBY;
                        v_level_q <= V_STBY;
                        busy_q    <= 1'b0;
                    end else if (!v_source_select) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cmd_err_q <= up_rise | dn_rise;
                        if (steps_left_q == 5'd0) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (timer_q == 8'd1) begin
                            steps_left_q <= steps_left_q - 5'd1;
                            timer_q      <= period_q;
                            if (clamp_d) begin
                                sat_q <= 1'b1;
                            end else begin
                                v_level_q <= v_step_d;
                                step_up_q <= step_is_up;
                                step_dn_q <= ~step_is_up;
                            end
                        end else begin
                            timer_q <= timer_q - 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    if (!Pwr_mode) begin
                        state_q   <= S_STBY;
                        v_level_q <= V_STBY;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_STBY: begin
                    busy_q <= 1'b0;
                    if (Pwr_mode) begin
                        state_q   <= S_IDLE;
                        v_level_q <= V_INIT;
                    end else begin
                        v_level_q <= V_STBY;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign v_level = v_level_q;
    assign step_up = step_up_q;
    assign step_dn = step_dn_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign sat     = sat_q;
    assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_vreg_ramp_ctrl.sv
// Directed bench for vreg_ramp_ctrl: per-cycle expected outputs are queued with each stimulus
// step and popped/compared one per clock, sampled 1 time unit after the rising edge.
module tb_vreg_ramp_ctrl;

    logic       clk = 1'b0;
    logic       reset, Pwr_mode, Vup, Vdn, v_source_select;
    logic [4:0] count;
    logic [7:0] rampTime;

    logic [7:0] v_lo, v_hi;
    logic       su_lo, sd_lo, bz_lo, dn_lo, st_lo, er_lo;
    logic       su_hi, sd_hi, bz_hi, dn_hi, st_hi, er_hi;

    typedef struct {
        string       tag;
        bit          hi;
        logic [13:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;

    vreg_ramp_ctrl dut (
        .clk(clk), .reset(reset), .Pwr_mode(Pwr_mode), .Vup(Vup), .Vdn(Vdn),
        .v_source_select(v_source_select), .count(count), .rampTime(rampTime),
        .v_level(v_lo), .step_up(su_lo), .step_dn(sd_lo), .busy(bz_lo),
        .done(dn_lo), .sat(st_lo), .cmd_err(er_lo)
    );

    vreg_ramp_ctrl #(.V_INIT(8'd198)) dut_hi (
        .clk(clk), .reset(reset), .Pwr_mode(Pwr_mode), .Vup(Vup), .Vdn(Vdn),
        .v_source_select(v_source_select), .count(count), .rampTime(rampTime),
        .v_level(v_hi), .step_up(su_hi), .step_dn(sd_hi), .busy(bz_hi),
        .done(dn_hi), .sat(st_hi), .cmd_err(er_hi)
    );

    function automatic void ex(string tag, bit hi, int v, bit su, bit sd, bit bz,
                               bit dn, bit st, bit er);
        exp_t e;
        logic [7:0] v8;
        v8    = v[7:0];
        e.tag = tag;
        e.hi  = hi;
        e.val = {v8, su, sd, bz, dn, st, er};
        exp_q.push_back(e);
    endfunction

    task automatic run(int n);
        exp_t        e;
        logic [13:0] obs;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                obs = e.hi ? {v_hi, su_hi, sd_hi, bz_hi, dn_hi, st_hi, er_hi}
                           : {v_lo, su_lo, sd_lo, bz_lo, dn_lo, st_lo, er_lo};
                checks++;
                assert (obs === e.val)
                else begin
                    errors++;
                    $error("FAIL %s @%0d: observed v=%0d flags(su,sd,bz,dn,sat,err)=%b expected v=%0d flags=%b",
                           e.tag, cyc, obs[13:6], obs[5:0], e.val[13:6], e.val[5:0]);
                end
                $display("check %s @%0d v=%0d flags=%b", e.tag, cyc, obs[13:6], obs[5:0]);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cyc += 2;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; Pwr_mode = 1'b1; Vup = 1'b0; Vdn = 1'b0;
        v_source_select = 1'b1; count = 5'd4; rampTime = 8'd3;

        // Reset state
        run(1);
        ex("rst_lo", 0, 128, 0, 0, 0, 0, 0, 0); run(1);
        ex("rst_hi", 1, 198, 0, 0, 0, 0, 0, 0); run(1);
        reset = 1'b0;
        ex("idle", 0, 128, 0, 0, 0, 0, 0, 0); run(1);

        // Up ramp, count=4, rampTime=3
        Vup = 1'b1;
        for (int c = 1; c <= 14; c++)
            ex($sformatf("up4_c%0d", c), 0, 128 + ((c <= 12) ? c / 3 : 4),
               (c <= 12) && (c % 3 == 0), 0, c <= 12, c == 13, 0, 0);
        run(14);
        Vup = 1'b0;

        // Clamp at V_MAX from 198, rampTime=0, count=5
        do_reset();
        count = 5'd5; rampTime = 8'd0; Vup = 1'b1;
        ex("clamp_c1", 1, 199, 1, 0, 1, 0, 0, 0);
        ex("clamp_c2", 1, 200, 1, 0, 1, 0, 0, 0);
        for (int c = 3; c <= 5; c++)
            ex($sformatf("clamp_c%0d", c), 1, 200, 0, 0, 1, 0, 1, 0);
        ex("clamp_done", 1, 200, 0, 0, 0, 1, 1, 0);
        ex("clamp_idle", 1, 200, 0, 0, 0, 0, 1, 0);
        run(7);
        Vup = 1'b0;
        do_reset();

        // Simultaneous edges, then count=0
        Vup = 1'b1; Vdn = 1'b1;
        ex("both_err", 0, 128, 0, 0, 0, 0, 0, 1);
        ex("both_after", 0, 128, 0, 0, 0, 0, 0, 0);
        run(2);
        Vup = 1'b0; Vdn = 1'b0;
        ex("low", 0, 128, 0, 0, 0, 0, 0, 0); run(1);
        count = 5'd0; Vdn = 1'b1;
        ex("cnt0_done", 0, 128, 0, 0, 0, 1, 0, 0);
        ex("cnt0_idle", 0, 128, 0, 0, 0, 0, 0, 0);
        run(2);

        // Down ramp with mid-ramp cmd_err, then standby abort
        Vdn = 1'b0; count = 5'd10; rampTime = 8'd2;
        ex("dn_pre", 0, 128, 0, 0, 0, 0, 0, 0); run(1);
        Vdn = 1'b1;
        ex("dn_c1", 0, 128, 0, 0, 1, 0, 0, 0); run(1);
        Vup = 1'b1;
        ex("dn_c2_err", 0, 127, 0, 1, 1, 0, 0, 1); run(1);
        Vup = 1'b0;
        ex("dn_c3", 0, 127, 0, 0, 1, 0, 0, 0);
        ex("dn_c4", 0, 126, 0, 1, 1, 0, 0, 0);
        run(2);
        Pwr_mode = 1'b0;
        ex("stby_enter", 0, 32, 0, 0, 0, 0, 0, 0); run(1);
        Vdn = 1'b0; Vup = 1'b1;
        ex("stby_ignore", 0, 32, 0, 0, 0, 0, 0, 0); run(1);
        Vup = 1'b0; Pwr_mode = 1'b1;
        ex("stby_exit", 0, 128, 0, 0, 0, 0, 0, 0); run(1);

        // Constant-driver mode: commands ignored, then mid-ramp abort
        v_source_select = 1'b0; Vup = 1'b1; Vdn = 1'b1;
        ex("cd_both1", 0, 128, 0, 0, 0, 0, 0, 0);
        ex("cd_both2", 0, 128, 0, 0, 0, 0, 0, 0);
        run(2);
        Vup = 1'b0; Vdn = 1'b0;
        ex("cd_low", 0, 128, 0, 0, 0, 0, 0, 0); run(1);
        Vup = 1'b1;
        ex("cd_up", 0, 128, 0, 0, 0, 0, 0, 0); run(1);
        Vup = 1'b0; v_source_select = 1'b1; count = 5'd4; rampTime = 8'd3;
        ex("cd_low2", 0, 128, 0, 0, 0, 0, 0, 0); run(1);
        Vup = 1'b1;
        ex("ab_c1", 0, 128, 0, 0, 1, 0, 0, 0);
        ex("ab_c2", 0, 128, 0, 0, 1, 0, 0, 0);
        ex("ab_c3", 0, 129, 1, 0, 1, 0, 0, 0);
        ex("ab_c4", 0, 129, 0, 0, 1, 0, 0, 0);
        run(4);
        v_source_select = 1'b0;
        ex("ab_idle1", 0, 129, 0, 0, 0, 0, 0, 0);
        ex("ab_idle2", 0, 129, 0, 0, 0, 0, 0, 0);
        run(2);
        Vup = 1'b0; v_source_select = 1'b1;
        ex("ab_low", 0, 129, 0, 0, 0, 0, 0, 0); run(1);

        // Reset during the third step period, then a fresh ramp
        Vup = 1'b1;
        ex("rr_c1", 0, 129, 0, 0, 1, 0, 0, 0);
        ex("rr_c2", 0, 129, 0, 0, 1, 0, 0, 0);
        ex("rr_c3", 0, 130, 1, 0, 1, 0, 0, 0);
        ex("rr_c4", 0, 130, 0, 0, 1, 0, 0, 0);
        ex("rr_c5", 0, 130, 0, 0, 1, 0, 0, 0);
        ex("rr_c6", 0, 131, 1, 0, 1, 0, 0, 0);
        ex("rr_c7", 0, 131, 0, 0, 1, 0, 0, 0);
        run(7);
        reset = 1'b1; Vup = 1'b0;
        ex("rr_reset", 0, 128, 0, 0, 0, 0, 0, 0); run(1);
        reset = 1'b0; count = 5'd2; rampTime = 8'd0;
        ex("rr_rel", 0, 128, 0, 0, 0, 0, 0, 0); run(1);
        Vup = 1'b1;
        ex("new_c1", 0, 129, 1, 0, 1, 0, 0, 0);
        ex("new_c2", 0, 130, 1, 0, 1, 0, 0, 0);
        ex("new_done", 0, 130, 0, 0, 0, 1, 0, 0);
        ex("new_idle", 0, 130, 0, 0, 0, 0, 0, 0);
        run(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
